// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 3-stage core: boot hold, load-use stall,
// redirect flush, external freeze, W->X forwarding selects and performance counters.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic        rs1_used_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rd_x,
  input  logic        is_load_x,
  input  logic        redirect_x,
  input  logic [4:0]  rs1_x,
  input  logic [4:0]  rs2_x,
  input  logic [4:0]  rd_w,
  input  logic        reg_we_w,
  input  logic        ext_stall_i,
  output logic        pc_en,
  output logic        ix_en,
  output logic        ix_bubble,
  output logic        xw_en,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  localparam logic [3:0] BOOT_LAST   = 4'(BOOT_CYCLES - 1);
  localparam logic [1:0] FLUSH_EXTRA = 2'(FLUSH_DEPTH - 1);

  state_t     state, state_next;
  logic [3:0] boot_cnt, boot_cnt_next;
  logic [1:0] flush_left, flush_left_next;
  logic       load_use;
  logic       count_stall;
  logic       count_flush;

  assign load_use = is_load_x && (rd_x != 5'd0) &&
                    ((rs1_used_i && (rs1_i == rd_x)) || (rs2_used_i && (rs2_i == rd_x)));

  assign fwd_a = reg_we_w && (rd_w != 5'd0) && (rd_w == rs1_x);
  assign fwd_b = reg_we_w && (rd_w != 5'd0) && (rd_w == rs2_x);

  // Reset outputs look like BOOT even before the state register has cleared;
  // a freeze zeroes every enable and holds all sequencing state.
  always_comb begin
    state_next      = state;
    boot_cnt_next   = boot_cnt;
    flush_left_next = flush_left;
    pc_en           = 1'b0;
    ix_en           = 1'b0;
    ix_bubble       = 1'b0;
    xw_en           = 1'b0;
    count_stall     = 1'b0;
    count_flush     = 1'b0;
    if (rst) begin
      ix_bubble = 1'b1;
      xw_en     = 1'b1;
    end else if (!ext_stall_i) begin
      case (state)
        BOOT: begin
          ix_bubble = 1'b1;
          xw_en     = 1'b1;
          if (boot_cnt == BOOT_LAST) begin
            state_next    = RUN;
            boot_cnt_next = 4'd0;
          end else begin
            boot_cnt_next = boot_cnt + 4'd1;
          end
        end
        RUN: begin
          xw_en = 1'b1;
          // A redirect makes the I instruction wrong-path, so it beats a load-use stall.
          if (redirect_x) begin
            pc_en       = 1'b1;
            ix_bubble   = 1'b1;
            count_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_next      = FLUSH;
              flush_left_next = FLUSH_EXTRA;
            end
          end else if (load_use) begin
            ix_bubble   = 1'b1;
            count_stall = 1'b1;
          end else begin
            pc_en = 1'b1;
            ix_en = 1'b1;
          end
        end
        FLUSH: begin
          pc_en     = 1'b1;
          ix_bubble = 1'b1;
          xw_en     = 1'b1;
          if (flush_left == 2'd1) begin
            state_next      = RUN;
            flush_left_next = 2'd0;
          end else begin
            flush_left_next = flush_left - 2'd1;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      boot_cnt   <= 4'd0;
      flush_left <= 2'd0;
      cycle_cnt  <= 32'd0;
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
    end else begin
      state      <= state_next;
      boot_cnt   <= boot_cnt_next;
      flush_left <= flush_left_next;
      cycle_cnt  <= cycle_cnt + 32'd1;
      if (count_stall) stall_cnt <= stall_cnt + 32'd1;
      if (count_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, each cycle
// checked against a behavioural model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int FLUSH_DEPTH = 2;

  typedef struct {
    logic       rst, ext, rdr, ld, u1, u2, we;
    logic [4:0] rs1, rs2, rdx, rs1x, rs2x, rdw;
  } stim_t;

  typedef struct {
    logic        pc, ix, bub, xw, fa, fb;
    logic [31:0] cyc, stl, fls;
    bit          cnt_ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rs1_used_i, rs2_used_i, is_load_x, redirect_x, reg_we_w, ext_stall_i;
  logic [4:0]  rs1_i, rs2_i, rd_x, rs1_x, rs2_x, rd_w;
  logic        pc_en, ix_en, ix_bubble, xw_en, fwd_a, fwd_b;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  // Reference model: cycles of boot hold / extra flush bubbles still owed, plus counters.
  int          m_boot_left  = 0;
  int          m_flush_left = 0;
  logic [31:0] m_cyc = 0, m_stl = 0, m_fls = 0;
  bit          m_known = 0;

  hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .clk(clk), .rst(rst), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i),
    .rs2_used_i(rs2_used_i), .rd_x(rd_x), .is_load_x(is_load_x), .redirect_x(redirect_x),
    .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_w(rd_w), .reg_we_w(reg_we_w), .ext_stall_i(ext_stall_i),
    .pc_en(pc_en), .ix_en(ix_en), .ix_bubble(ix_bubble), .xw_en(xw_en), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, ext: 1'b0, rdr: 1'b0, ld: 1'b0, u1: 1'b0, u2: 1'b0, we: 1'b0,
          rs1: 5'd0, rs2: 5'd0, rdx: 5'd0, rs1x: 5'd0, rs2x: 5'd0, rdw: 5'd0};
    return s;
  endfunction

  // Drives one cycle of inputs, predicts that cycle's outputs, then advances the model.
  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    rst = s.rst; ext_stall_i = s.ext; redirect_x = s.rdr; is_load_x = s.ld;
    rs1_used_i = s.u1; rs2_used_i = s.u2; reg_we_w = s.we;
    rs1_i = s.rs1; rs2_i = s.rs2; rd_x = s.rdx; rs1_x = s.rs1x; rs2_x = s.rs2x; rd_w = s.rdw;

    hazard = s.ld && s.rdx != 0 && ((s.u1 && s.rs1 == s.rdx) || (s.u2 && s.rs2 == s.rdx));
    e.fa = s.we && s.rdw != 0 && s.rdw == s.rs1x;
    e.fb = s.we && s.rdw != 0 && s.rdw == s.rs2x;
    if (s.rst)                 {e.pc, e.ix, e.bub, e.xw} = 4'b0011;
    else if (s.ext)            {e.pc, e.ix, e.bub, e.xw} = 4'b0000;
    else if (m_boot_left > 0)  {e.pc, e.ix, e.bub, e.xw} = 4'b0011;
    else if (m_flush_left > 0) {e.pc, e.ix, e.bub, e.xw} = 4'b1011;
    else if (s.rdr)            {e.pc, e.ix, e.bub, e.xw} = 4'b1011;
    else if (hazard)           {e.pc, e.ix, e.bub, e.xw} = 4'b0011;
    else                       {e.pc, e.ix, e.bub, e.xw} = 4'b1101;
    e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls; e.cnt_ok = m_known;
    exp_q.push_back(e);

    if (s.rst) begin
      m_boot_left = BOOT_CYCLES; m_flush_left = 0;
      m_cyc = 0; m_stl = 0; m_fls = 0; m_known = 1;
    end else begin
      m_cyc = m_cyc + 1;
      if (!s.ext) begin
        if (m_boot_left > 0) m_boot_left--;
        else if (m_flush_left > 0) m_flush_left--;
        else if (s.rdr) begin m_fls = m_fls + 1; m_flush_left = FLUSH_DEPTH - 1; end
        else if (hazard) m_stl = m_stl + 1;
      end
    end
  endtask

  // Monitor: every cycle presents a response; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("pc_en",     {31'd0, pc_en},     {31'd0, e.pc});
        check_output("ix_en",     {31'd0, ix_en},     {31'd0, e.ix});
        check_output("ix_bubble", {31'd0, ix_bubble}, {31'd0, e.bub});
        check_output("xw_en",     {31'd0, xw_en},     {31'd0, e.xw});
        check_output("fwd_a",     {31'd0, fwd_a},     {31'd0, e.fa});
        check_output("fwd_b",     {31'd0, fwd_b},     {31'd0, e.fb});
        if (e.cnt_ok) begin
          check_output("cycle_cnt", cycle_cnt, e.cyc);
          check_output("stall_cnt", stall_cnt, e.stl);
          check_output("flush_cnt", flush_cnt, e.fls);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst = 1'b1; ext_stall_i = 1'b0; redirect_x = 1'b0; is_load_x = 1'b0;
    rs1_used_i = 1'b0; rs2_used_i = 1'b0; reg_we_w = 1'b0;
    rs1_i = 0; rs2_i = 0; rd_x = 0; rs1_x = 0; rs2_x = 0; rd_w = 0;

    // Boot: three reset cycles, then five idle cycles.
    s = idle(); s.rst = 1'b1;
    repeat (3) apply_stimulus(s);
    repeat (5) apply_stimulus(idle());

    // Load-use on rs2, followed by W->X forwarding of the loaded value.
    s = idle(); s.ld = 1'b1; s.rdx = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    apply_stimulus(s);
    check_output("cycle_cnt_boot", cycle_cnt, 32'd5);
    s = idle(); s.rdw = 5'd5; s.we = 1'b1; s.rs2x = 5'd5;
    apply_stimulus(s);
    check_output("stall_cnt_loaduse", stall_cnt, 32'd1);

    // x0 destination, unused source, and x0 writeback never interlock or forward.
    s = idle(); s.ld = 1'b1; s.rdx = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    apply_stimulus(s);
    s = idle(); s.ld = 1'b1; s.rdx = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0;
    apply_stimulus(s);
    s = idle(); s.we = 1'b1; s.rdw = 5'd0; s.rs1x = 5'd0;
    apply_stimulus(s);
    check_output("stall_cnt_x0", stall_cnt, 32'd1);

    // Fresh reset, then redirect colliding with a load-use hazard.
    s = idle(); s.rst = 1'b1;
    apply_stimulus(s);
    repeat (BOOT_CYCLES) apply_stimulus(idle());
    s = idle(); s.rdr = 1'b1; s.ld = 1'b1; s.rdx = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
    apply_stimulus(s);
    apply_stimulus(idle());

    // Freeze for four cycles with a redirect pending, then release it.
    s = idle(); s.rdr = 1'b1; s.ext = 1'b1;
    apply_stimulus(s);
    check_output("flush_cnt_redirect", flush_cnt, 32'd1);
    check_output("stall_cnt_redirect", stall_cnt, 32'd0);
    repeat (3) apply_stimulus(s);
    s.ext = 1'b0;
    apply_stimulus(s);
    check_output("flush_cnt_frozen", flush_cnt, 32'd1);

    // Reset during the first FLUSH cycle.
    s = idle(); s.rst = 1'b1;
    apply_stimulus(s);
    check_output("flush_cnt_release", flush_cnt, 32'd2);
    apply_stimulus(idle());
    check_output("cycle_cnt_rst_flush", cycle_cnt, 32'd0);
    check_output("flush_cnt_rst_flush", flush_cnt, 32'd0);

    // Random traffic over a small register set to provoke hazards and forwarding.
    for (int i = 0; i < 2000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.ext  = ($urandom_range(0, 7) == 0);
      s.rdr  = ($urandom_range(0, 7) == 0);
      s.ld   = $urandom_range(0, 1);
      s.u1   = $urandom_range(0, 1);
      s.u2   = $urandom_range(0, 1);
      s.we   = $urandom_range(0, 1);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rdx  = 5'($urandom_range(0, 3));
      s.rs1x = 5'($urandom_range(0, 3));
      s.rs2x = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      apply_stimulus(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
